// File: rtl/add3_sequencer_pkg.sv
// add3_seq_pkg: shared state encoding and seven-segment codes for add3_sequencer.
// Segment codes are active-high, bit7 = decimal point (used as minus sign),
// bits[6:0] = gfedcba.
package add3_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    ADD   = 2'd2,
    SHOW  = 2'd3
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_NEG   = 8'h80;

  // Magnitude digits 0..4; a 3-bit signed value never exceeds |4|.
  localparam logic [7:0] SEG_DIG [0:4] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66};

endpackage

// File: rtl/add3_sequencer_if.sv
// add3_sequencer_if: operand/step inputs and all observable outputs of the
// sequencer. The slave modport is the sequencer, master is whatever drives it.
//
// Handshake: there is no valid/ready pair. step is a raw asynchronous level;
// the sequencer synchronizes it and acts once per 0->1 transition. op_in is
// sampled only in the cycle that transition is recognized, so it must be held
// stable from the rising step until the state has advanced.
interface add3_sequencer_if #(
  parameter int NBITS    = 3,
  parameter int CNT_BITS = 4
);
  logic                step;
  logic [NBITS-1:0]    op_in;
  logic [NBITS-1:0]    op_a;
  logic [NBITS-1:0]    op_b;
  logic [NBITS-1:0]    result;
  logic                ovf;
  logic                busy;
  logic [1:0]          state_o;
  logic [CNT_BITS-1:0] op_count;
  logic [7:0]          seg;

  modport master (
    output step, op_in,
    input  op_a, op_b, result, ovf, busy, state_o, op_count, seg
  );

  modport slave (
    input  step, op_in,
    output op_a, op_b, result, ovf, busy, state_o, op_count, seg
  );
endinterface

// File: rtl/add3_sequencer_seg_signed_dec.sv
// seg_signed_dec: combinational decode of an NBITS two's-complement value to
// one seven-segment digit. The DP (bit7) lights for negative values; an
// overflow flag overrides the digit with 'E'.
module seg_signed_dec
  import add3_seq_pkg::*;
#(
  parameter int NBITS = 3
) (
  input  logic [NBITS-1:0] value_i,
  input  logic             ovf_i,
  output logic [7:0]       seg_o
);

  logic             sign;
  logic [NBITS-1:0] mag;
  logic [7:0]       digit;

  // Sign/magnitude split and digit lookup; -4 negates to itself, which as an
  // unsigned magnitude is 4, exactly the digit we want.
  always_comb begin
    sign  = value_i[NBITS-1];
    mag   = sign ? -value_i : value_i;
    digit = SEG_BLANK;
    case (int'(mag))
      0:       digit = SEG_DIG[0];
      1:       digit = SEG_DIG[1];
      2:       digit = SEG_DIG[2];
      3:       digit = SEG_DIG[3];
      4:       digit = SEG_DIG[4];
      default: digit = SEG_BLANK;
    endcase
    if (ovf_i) seg_o = SEG_E;
    else       seg_o = digit | (sign ? SEG_NEG : SEG_BLANK);
  end

endmodule

// File: rtl/add3_sequencer.sv
// add3_sequencer: latches operand A then B on successive step presses, adds
// them (with signed overflow), and shows the result on one seven-segment digit.
// Optional feature macro ADD3_ACC_CHAIN_EN: a step in SHOW without overflow
// reloads the result as operand A and waits for a new B (accumulate chain).
// SYNC_STAGES must be at least 2.
module add3_sequencer
  import add3_seq_pkg::*;
#(
  parameter int NBITS       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_BITS    = 4
) (
  input  logic               clk_2,
  input  logic               reset,
  add3_sequencer_if.slave    bus
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   step_p;

  state_t                 state_q, state_d;
  logic [NBITS-1:0]       op_a_q, op_a_d;
  logic [NBITS-1:0]       op_b_q, op_b_d;
  logic [NBITS-1:0]       result_q, result_d;
  logic                   ovf_q, ovf_d;
  logic                   busy_q, busy_d;
  logic [CNT_BITS-1:0]    count_q, count_d;
  logic [7:0]             seg_q, seg_d;

  logic [NBITS-1:0]       sum;
  logic [NBITS-1:0]       dec_val;
  logic                   dec_ovf;
  logic [7:0]             dec_seg;

  // Synchronize the raw step level and keep one history flop for edge detect.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.step};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign step_p = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign sum    = op_a_q + op_b_q;

  // Next-state and next-output logic; a pulse arriving during ADD is dropped.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    count_d  = count_q;
    case (state_q)
      IDLE: if (step_p) begin
        op_a_d  = bus.op_in;
        state_d = GOT_A;
      end
      GOT_A: if (step_p) begin
        op_b_d  = bus.op_in;
        state_d = ADD;
      end
      ADD: begin
        result_d = sum;
        ovf_d    = (op_a_q[NBITS-1] == op_b_q[NBITS-1]) &&
                   (sum[NBITS-1] != op_a_q[NBITS-1]);
        if (count_q != CNT_MAX) count_d = count_q + 1'b1;
        state_d  = SHOW;
      end
      SHOW: if (step_p) begin
`ifdef ADD3_ACC_CHAIN_EN
        if (!ovf_q) begin
          op_a_d  = result_q;
          state_d = GOT_A;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ADD);
  end

  // Display source follows the state being entered so seg is valid on entry.
  always_comb begin
    dec_val = (state_d == SHOW) ? result_d : op_a_d;
    dec_ovf = (state_d == SHOW) & ovf_d;
    seg_d   = (state_d == IDLE) ? SEG_BLANK : dec_seg;
  end

  seg_signed_dec #(.NBITS(NBITS)) u_dec (
    .value_i (dec_val),
    .ovf_i   (dec_ovf),
    .seg_o   (dec_seg)
  );

  // State and all registered outputs.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= '0;
      seg_q    <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.result   = result_q;
  assign bus.ovf      = ovf_q;
  assign bus.busy     = busy_q;
  assign bus.state_o  = state_q;
  assign bus.op_count = count_q;
  assign bus.seg      = seg_q;

endmodule

// File: tb/tb_add3_sequencer.sv
// tb_add3_sequencer: directed and random step/operand sequences against a
// signed-arithmetic reference of the add3_sequencer.
// Build with +define+ADD3_ACC_CHAIN_EN to exercise the accumulate chain.
module tb_add3_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  add3_sequencer_if #(.NBITS(3), .CNT_BITS(4)) bus();

  add3_sequencer #(.NBITS(3), .SYNC_STAGES(2), .CNT_BITS(4)) dut (
    .clk_2 (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: plain integers, signed arithmetic.
  int m_state;
  int m_a, m_b, m_res, m_cnt, m_adds;
  bit m_ovf;

  // Monitors: busy-high cycles and state transitions, sampled on negedge.
  int       busy_cycles = 0;
  int       transitions = 0;
  logic [1:0] prev_state = 2'd0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.state_o !== prev_state) transitions++;
    end
    prev_state = bus.state_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  function automatic int to_signed3(input int v);
    return (v >= 4) ? v - 8 : v;
  endfunction

  // Expected display for a value: 'E' on overflow, else |v| digit with DP for negatives.
  function automatic int disp(input int v, input bit ovf);
    int tbl[5] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66};
    int s;
    s = to_signed3(v);
    if (ovf) return 'h79;
    if (s < 0) return tbl[-s] | 'h80;
    return tbl[s];
  endfunction

  function automatic int exp_seg();
    case (m_state)
      1:       return disp(m_a, 1'b0);
      3:       return disp(m_res, m_ovf);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_ovf = 0; m_cnt = 0;
  endtask

  // One recognized step press, with the operand presented at that time.
  task automatic model_press(input int v);
    int s;
    case (m_state)
      0: begin m_a = v; m_state = 1; end
      1: begin
        m_b   = v;
        s     = to_signed3(m_a) + to_signed3(m_b);
        m_ovf = (s > 3) || (s < -4);
        m_res = (s + 8) % 8;
        if (m_cnt < 15) m_cnt++;
        m_adds++;
        m_state = 3;
      end
      3: begin
`ifdef ADD3_ACC_CHAIN_EN
        if (!m_ovf) begin m_a = m_res; m_state = 1; end
        else m_state = 0;
`else
        m_state = 0;
`endif
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".state"},  32'(bus.state_o),  32'(m_state));
    check_eq({tag, ".op_a"},   32'(bus.op_a),     32'(m_a));
    check_eq({tag, ".op_b"},   32'(bus.op_b),     32'(m_b));
    check_eq({tag, ".result"}, 32'(bus.result),   32'(m_res));
    check_eq({tag, ".ovf"},    32'(bus.ovf),      32'(m_ovf));
    check_eq({tag, ".busy"},   32'(bus.busy),     32'd0);
    check_eq({tag, ".count"},  32'(bus.op_count), 32'(m_cnt));
    check_eq({tag, ".seg"},    32'(bus.seg),      32'(exp_seg()));
    check_eq({tag, ".busy_cyc"}, 32'(busy_cycles), 32'(m_adds));
  endtask

  // Drive a press: hold step long enough to be recognized, then release and
  // scramble op_in to show it is ignored outside the latch cycle.
  task automatic press(input int v, input int hold);
    @(negedge clk);
    bus.op_in = 3'(v);
    bus.step  = 1'b1;
    repeat (hold) @(negedge clk);
    bus.step  = 1'b0;
    bus.op_in = 3'($urandom_range(0, 7));
    repeat (4) @(negedge clk);
    model_press(v);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    check_eq({tag, ".state"}, 32'(bus.state_o), 32'd0);
    check_eq({tag, ".op_a"},  32'(bus.op_a),    32'd0);
    check_eq({tag, ".seg"},   32'(bus.seg),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_add(input string tag, input int a, input int b);
    press(a, $urandom_range(3, 8));
    press(b, $urandom_range(3, 8));
    check_all(tag);
  endtask

  initial begin
    int t0;
    m_adds = 0;
    model_reset();
    bus.step  = 1'b0;
    bus.op_in = 3'd0;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    @(negedge clk);

    // Held step: latency of SYNC_STAGES+1 edges and exactly one transition.
    t0 = transitions;
    bus.op_in = 3'd2;
    bus.step  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("lat_pre", 32'(bus.state_o), 32'd0);
    @(negedge clk);
    check_eq("lat_post", 32'(bus.state_o), 32'd1);
    repeat (7) @(negedge clk);
    bus.step = 1'b0;
    repeat (4) @(negedge clk);
    model_press(2);
    check_eq("held_one_trans", 32'(transitions - t0), 32'd1);
    check_all("held");

    // A=2 (already latched), B=1 -> 3, no overflow, seg 0x4F.
    press(1, 4);
    check_all("a2b1");
    check_eq("a2b1.seg_const", 32'(bus.seg), 32'h4F);
    press(0, 4);
    check_all("dismiss1");

    do_add("a3b2", 3, 2);
    check_eq("a3b2.seg_const", 32'(bus.seg), 32'h79);
    press(0, 4);
    do_add("am1bm2", 7, 6);
    check_eq("am1bm2.seg_const", 32'(bus.seg), 32'hCF);
    press(0, 4);
    do_add("am4b0", 4, 0);
    check_eq("am4b0.seg_const", 32'(bus.seg), 32'hE6);
    press(0, 4);

    // Reset in GOT_A with op_a=3, then a normal sequence.
    press(3, 4);
    check_all("gota3");
    async_reset("rst_mid");
    check_all("after_rst");
    do_add("post_rst", 1, 2);
    press(0, 4);
    check_all("show_step");

`ifdef ADD3_ACC_CHAIN_EN
    // Accumulate chain: 1+1=2, then +1=3.
    do_add("chain1", 1, 1);
    press(0, 4);
    check_all("chain_reload");
    press(1, 4);
    check_all("chain2");
    check_eq("chain2.result_const", 32'(bus.result), 32'd3);
    press(0, 4);
    press(0, 4);
`endif

    // Saturation: drive past 16 completed additions.
    for (int i = 0; i < 17; i++) begin
      if (m_state == 3) press(0, 3);
      if (m_state == 0) press($urandom_range(0, 7), 3);
      press($urandom_range(0, 7), 3);
    end
    check_all("sat");
    check_eq("sat.count_const", 32'(bus.op_count), 32'd15);

    // Random sequences with occasional asynchronous resets.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 14) == 0) async_reset("rnd_rst");
      press($urandom_range(0, 7), $urandom_range(3, 10));
      check_all("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
